// File: rtl/commit_result_sender_pkg.sv
// Shared types for the scalar commit path.
// Record layout and derived widths.
package commit_result_sender_pkg;

  localparam int THREAD_CNT     = 4;
  localparam int WARP_CNT       = 4;
  localparam int WARP_CNT_WIDTH =
    (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1;
  localparam int UUID_WIDTH     = 16;
  localparam int XLEN           = 32;
  localparam int NR_BITS        = 5;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]            uuid;
    logic [WARP_CNT_WIDTH-1:0]        wid;
    logic [THREAD_CNT-1:0]            tmask;
    logic [XLEN-1:0]                  pc;
    logic                             wb;
    logic [NR_BITS-1:0]               rd;
    logic [THREAD_CNT-1:0][XLEN-1:0]  data;
    logic                             sop;
    logic                             eop;
    logic                             halt;
  } commit_scalar_data_t;

  localparam int COMMIT_DATAW = $bits(commit_scalar_data_t);

  function automatic int pend_width(input int max);
    return (max + 1 > 1) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/commit_result_sender_if.sv
// Valid/ready channel carrying one commit record.
// Used on both the execute side and the commit side.
interface commit_result_sender_if;
  import commit_result_sender_pkg::*;

  logic                valid;
  commit_scalar_data_t data;
  logic                ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/commit_sender_fifo.sv
// Registered result FIFO, wrap-bit pointers.
// Head is read straight from storage; no bypass.
module commit_sender_fifo
  import commit_result_sender_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  commit_scalar_data_t wdata,
  output commit_scalar_data_t rdata,
  output logic                full,
  output logic                empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]      wr_ptr;
  logic [IDX_W:0]      rd_ptr;
  commit_scalar_data_t mem [DEPTH];
  logic                do_push;
  logic                do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is cleared so the head never shows X.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[IDX_W-1:0]] <= wdata;
        wr_ptr <= wr_ptr + (IDX_W+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (IDX_W+1)'(1);
      end
    end
  end

  assign full =
    (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/commit_result_sender.sv
// Execute-side commit transmitter: result FIFO
// plus per-warp in-flight instruction counters.
module commit_result_sender
  import commit_result_sender_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MAX_PENDING = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  commit_result_sender_if.slave     res_if,
  commit_result_sender_if.master    commit_if,
  input  logic                      disp_valid,
  input  logic [WARP_CNT_WIDTH-1:0] disp_wid,
  output logic                      disp_ready,
  output logic [WARP_CNT-1:0]       pending,
  output logic                      empty
);

  localparam int PEND_W = pend_width(MAX_PENDING);

  commit_scalar_data_t head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                dec;
  logic [PEND_W-1:0]   cnt [WARP_CNT];
  logic [WARP_CNT-1:0] inc_vec;
  logic [WARP_CNT-1:0] dec_vec;

  commit_sender_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (res_if.data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_if.ready     = !fifo_full;
  assign commit_if.valid  = !fifo_empty;
  assign commit_if.data   = head;

  assign push = res_if.valid && res_if.ready;
  assign pop  = commit_if.valid && commit_if.ready;
  assign dec  = pop && head.eop;

  // Registered count only; a same-cycle retire is not seen.
  assign disp_ready = cnt[disp_wid] < PEND_W'(MAX_PENDING);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    pending = '0;
    for (int w = 0; w < WARP_CNT; w++) begin
      inc_vec[w] = disp_valid && disp_ready &&
                   (disp_wid == WARP_CNT_WIDTH'(w));
      dec_vec[w] = dec &&
                   (head.wid == WARP_CNT_WIDTH'(w));
      pending[w] = (cnt[w] != '0);
    end
  end

  assign empty = fifo_empty && ~|pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < WARP_CNT; w++) begin
        cnt[w] <= '0;
      end
    end else begin
      for (int w = 0; w < WARP_CNT; w++) begin
        unique case ({inc_vec[w], dec_vec[w]})
          2'b10: cnt[w] <= cnt[w] + PEND_W'(1);
          2'b01: begin
            if (cnt[w] != '0) begin
              cnt[w] <= cnt[w] - PEND_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(dec && cnt[head.wid] == '0))
        else $error("commit underflow wid=%0d", head.wid);
      assert (!(push && cnt[res_if.data.wid] == '0))
        else $error("push with no pending wid=%0d",
                    res_if.data.wid);
    end
  end
`endif

endmodule

// File: tb/tb_commit_result_sender.sv
// Bench for commit_result_sender: directed scenarios
// and random traffic against a queue/counter model.
module tb_commit_result_sender;
  import commit_result_sender_pkg::*;

  localparam int DEPTH       = 4;
  localparam int MAX_PENDING = 8;

  logic                      clk;
  logic                      reset;
  logic                      disp_valid;
  logic [WARP_CNT_WIDTH-1:0] disp_wid;
  logic                      disp_ready;
  logic [WARP_CNT-1:0]       pending;
  logic                      empty;

  commit_result_sender_if res_if ();
  commit_result_sender_if commit_if ();

  commit_result_sender #(
    .DEPTH       (DEPTH),
    .MAX_PENDING (MAX_PENDING)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .res_if     (res_if),
    .commit_if  (commit_if),
    .disp_valid (disp_valid),
    .disp_wid   (disp_wid),
    .disp_ready (disp_ready),
    .pending    (pending),
    .empty      (empty)
  );

  int vectors;
  int miscompares;
  int uid;

  commit_scalar_data_t q [$];
  int                  mcnt [WARP_CNT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic commit_scalar_data_t mk_rec(
    input int u, input int w, input bit eop);
    commit_scalar_data_t r;
    r.uuid  = UUID_WIDTH'(u);
    r.wid   = WARP_CNT_WIDTH'(w);
    r.tmask = THREAD_CNT'($urandom);
    r.pc    = $urandom;
    r.wb    = 1'($urandom);
    r.rd    = NR_BITS'($urandom);
    for (int t = 0; t < THREAD_CNT; t++) r.data[t] = $urandom;
    r.sop   = 1'($urandom);
    r.eop   = eop;
    r.halt  = 1'($urandom);
    return r;
  endfunction

  function automatic logic [WARP_CNT-1:0] exp_pending();
    logic [WARP_CNT-1:0] p;
    p = '0;
    for (int w = 0; w < WARP_CNT; w++) p[w] = (mcnt[w] != 0);
    return p;
  endfunction

  // One clock: model follows the FIFO/counter rules, ends at negedge.
  task automatic tick();
    bit do_push, do_pop, do_inc, do_dec;
    int dw, iw;
    commit_scalar_data_t pd;
    do_push = res_if.valid && (q.size() < DEPTH);
    do_pop  = commit_if.ready && (q.size() > 0);
    iw      = int'(disp_wid);
    do_inc  = disp_valid && (mcnt[iw] < MAX_PENDING);
    do_dec  = do_pop && q[0].eop;
    dw      = do_pop ? int'(q[0].wid) : 0;
    pd      = res_if.data;
    @(posedge clk);
    if (reset) begin
      q.delete();
      for (int w = 0; w < WARP_CNT; w++) mcnt[w] = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(pd);
      if (do_inc) mcnt[iw]++;
      if (do_dec && mcnt[dw] > 0) mcnt[dw]--;
    end
    @(negedge clk);
  endtask

  task automatic dispatch(input int w, input int n);
    for (int i = 0; i < n; i++) begin
      disp_valid = 1'b1;
      disp_wid   = WARP_CNT_WIDTH'(w);
      tick();
    end
    disp_valid = 1'b0;
  endtask

  task automatic push_drain(input int w, input int n);
    commit_if.ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      res_if.valid = 1'b1;
      res_if.data  = mk_rec(uid++, w, 1'b1);
      tick();
    end
    res_if.valid = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) if (q.size() > 0) tick();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    res_if.valid = 1'b1;
    res_if.data  = mk_rec(99, 0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (res_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_res_ready got=%b exp=1", res_if.ready);
    end
    vectors++;
    if (commit_if.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_commit_valid got=%b exp=0",
               commit_if.valid);
    end
    vectors++;
    if (pending !== '0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pend_empty got=%b/%b exp=0000/1",
               pending, empty);
    end
    vectors++;
    if (disp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_disp_ready got=%b exp=1", disp_ready);
    end
    reset        = 1'b0;
    res_if.valid = 1'b0;
    tick();
    vectors++;
    if (commit_if.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_push got=%b exp=0", commit_if.valid);
    end
  endtask

  task automatic test_latency_order();
    commit_scalar_data_t r [3];
    dispatch(0, 3);
    commit_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) r[i] = mk_rec(i + 1, 0, 1'b1);
    res_if.valid = 1'b1;
    res_if.data  = r[0];
    vectors++;
    if (commit_if.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_no_bypass got=%b exp=0", commit_if.valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) res_if.data = r[i + 1];
      else res_if.valid = 1'b0;
      vectors++;
      if (commit_if.valid !== 1'b1 || commit_if.data !== r[i]) begin
        miscompares++;
        $display("FAIL lat_order%0d got=%b/%h exp=1/%h", i,
                 commit_if.valid, commit_if.data, r[i]);
      end
    end
    tick();
    vectors++;
    if (commit_if.valid !== 1'b0 || pending[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_drained got=%b/%b exp=0/0",
               commit_if.valid, pending[0]);
    end
  endtask

  task automatic test_backpressure();
    commit_scalar_data_t r [5];
    dispatch(1, 5);
    commit_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) r[i] = mk_rec(10 + i, 1, 1'b1);
    res_if.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_if.data = r[i];
      tick();
      vectors++;
      if (res_if.ready !== (i < 3)) begin
        miscompares++;
        $display("FAIL bp_ready%0d got=%b exp=%b", i,
                 res_if.ready, (i < 3));
      end
    end
    res_if.data = r[4];
    tick();
    tick();
    vectors++;
    if (res_if.ready !== 1'b0 || commit_if.valid !== 1'b1 ||
        commit_if.data !== r[0]) begin
      miscompares++;
      $display("FAIL bp_hold got=%b/%b/%h exp=0/1/%h",
               res_if.ready, commit_if.valid, commit_if.data, r[0]);
    end
    commit_if.ready = 1'b1;
    tick();
    vectors++;
    if (q.size() != 3 || commit_if.data !== r[1] ||
        res_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full_pop got=%h/%b exp=%h/1",
               commit_if.data, res_if.ready, r[1]);
    end
    tick();
    res_if.valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      vectors++;
      if (commit_if.valid !== 1'b1 || commit_if.data !== r[i]) begin
        miscompares++;
        $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i,
                 commit_if.valid, commit_if.data, r[i]);
      end
      tick();
    end
    vectors++;
    if (commit_if.valid !== 1'b0 || pending !== '0) begin
      miscompares++;
      $display("FAIL bp_end got=%b/%b exp=0/0000",
               commit_if.valid, pending);
    end
  endtask

  task automatic test_pending();
    dispatch(2, 8);
    disp_wid = 2'd2;
    #1;
    vectors++;
    if (disp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pend_full_w2 got=%b exp=0", disp_ready);
    end
    disp_wid = 2'd0;
    #1;
    vectors++;
    if (disp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pend_free_w0 got=%b exp=1", disp_ready);
    end
    dispatch(2, 1);
    commit_if.ready = 1'b0;
    res_if.valid = 1'b1;
    res_if.data  = mk_rec(uid++, 2, 1'b0);
    tick();
    res_if.valid = 1'b0;
    commit_if.ready = 1'b1;
    tick();
    commit_if.ready = 1'b0;
    disp_wid = 2'd2;
    #1;
    vectors++;
    if (disp_ready !== 1'b0 || pending[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL pend_sop got=%b/%b exp=0/1",
               disp_ready, pending[2]);
    end
    res_if.valid = 1'b1;
    res_if.data  = mk_rec(uid++, 2, 1'b1);
    tick();
    res_if.valid = 1'b0;
    commit_if.ready = 1'b1;
    #1;
    vectors++;
    if (disp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pend_same_cyc got=%b exp=0", disp_ready);
    end
    tick();
    vectors++;
    if (disp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pend_eop got=%b exp=1", disp_ready);
    end
    push_drain(2, 7);
    vectors++;
    if (pending !== '0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL pend_clear got=%b/%b exp=0000/1",
               pending, empty);
    end
  endtask

  task automatic test_simul();
    dispatch(1, 3);
    commit_if.ready = 1'b0;
    res_if.valid = 1'b1;
    res_if.data  = mk_rec(uid++, 1, 1'b1);
    tick();
    res_if.valid    = 1'b0;
    commit_if.ready = 1'b1;
    disp_valid      = 1'b1;
    disp_wid        = 2'd1;
    tick();
    disp_valid      = 1'b0;
    vectors++;
    if (pending[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_pend got=%b exp=1", pending[1]);
    end
    push_drain(1, 2);
    vectors++;
    if (pending[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_cnt1 got=%b exp=1", pending[1]);
    end
    push_drain(1, 1);
    vectors++;
    if (pending[1] !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_zero got=%b/%b exp=0/1",
               pending[1], empty);
    end
  endtask

  task automatic test_reset_mid();
    dispatch(0, 2);
    commit_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_if.valid = 1'b1;
      res_if.data  = mk_rec(uid++, 0, 1'b1);
      tick();
    end
    res_if.valid = 1'b0;
    reset = 1'b1;
    tick();
    vectors++;
    if (commit_if.valid !== 1'b0 || pending !== '0 ||
        res_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset got=%b/%b/%b exp=0/0000/1",
               commit_if.valid, pending, res_if.ready);
    end
    reset = 1'b0;
    commit_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (commit_if.valid !== 1'b0 || empty !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_stale%0d got=%b/%b exp=0/1", i,
                 commit_if.valid, empty);
      end
    end
  endtask

  task automatic test_random();
    int w, eq;
    bit eop, ok;
    for (int c = 0; c < 400; c++) begin
      commit_if.ready = ($urandom_range(0, 3) != 0);
      disp_valid = 1'($urandom_range(0, 1));
      disp_wid   = WARP_CNT_WIDTH'($urandom_range(0, WARP_CNT - 1));
      w   = $urandom_range(0, WARP_CNT - 1);
      eop = ($urandom_range(0, 3) != 0);
      eq  = 0;
      foreach (q[i]) if (int'(q[i].wid) == w && q[i].eop) eq++;
      ok  = eop ? (mcnt[w] > eq) : (mcnt[w] > 0);
      res_if.valid = ok && 1'($urandom_range(0, 1));
      res_if.data  = mk_rec(uid++, w, eop);
      #1;
      vectors++;
      if (res_if.ready !== (q.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL rnd_ready c=%0d got=%b", c, res_if.ready);
      end
      vectors++;
      if (commit_if.valid !== (q.size() > 0)) begin
        miscompares++;
        $display("FAIL rnd_valid c=%0d got=%b exp=%b", c,
                 commit_if.valid, (q.size() > 0));
      end
      if (q.size() > 0) begin
        vectors++;
        if (commit_if.data !== q[0]) begin
          miscompares++;
          $display("FAIL rnd_data c=%0d got=%h exp=%h", c,
                   commit_if.data, q[0]);
        end
      end
      vectors++;
      if (disp_ready !== (mcnt[int'(disp_wid)] < MAX_PENDING)) begin
        miscompares++;
        $display("FAIL rnd_disp c=%0d got=%b", c, disp_ready);
      end
      vectors++;
      if (pending !== exp_pending() ||
          empty !== (q.size() == 0 && exp_pending() == '0)) begin
        miscompares++;
        $display("FAIL rnd_pend c=%0d got=%b/%b exp=%b", c,
                 pending, empty, exp_pending());
      end
      tick();
    end
    res_if.valid = 1'b0;
    disp_valid   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    uid         = 100;
    for (int w = 0; w < WARP_CNT; w++) mcnt[w] = 0;
    reset           = 1'b1;
    disp_valid      = 1'b0;
    disp_wid        = '0;
    res_if.valid    = 1'b0;
    res_if.data     = '0;
    commit_if.ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency_order();
    test_backpressure();
    test_pending();
    test_simul();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
